// File: rtl/rsv_station_pkg.sv
// rsv_station_pkg: shared types, sizes and the entry record for the reservation station.
package rsv_station_pkg;
   localparam int RSV_CAPACITY = 8;
   localparam int NUM_WB = 2;
   typedef logic [5:0] FuncCode_t;
   typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_LSU, FU_BR} FuncUnitType_t;
   typedef logic [5:0] VRegIdx_t;
   // src/src_type/src_rdy are indexed [0]=a, [1]=b, [2]=c
   typedef struct packed {
      FuncCode_t op;
      FuncUnitType_t fu_type;
      VRegIdx_t [2:0] src;
      logic [2:0] src_type;
      logic [2:0] src_rdy;
      VRegIdx_t rd;
      logic rdt;
      logic rd_valid;
   } RsvEntry_t;
endpackage

// File: rtl/rsv_station_if.sv
// rsv_station_if: rename alloc, writeback broadcast, dispatch ack and per-entry op vectors.
interface rsv_station_if #(
   parameter int N = rsv_station_pkg::RSV_CAPACITY,
   parameter int W = rsv_station_pkg::NUM_WB
);
   import rsv_station_pkg::*;
   logic flush;
   logic allocValid, allocReady;
   FuncCode_t allocOp;
   FuncUnitType_t allocFuType;
   VRegIdx_t allocRa, allocRb, allocRc, allocRd;
   logic [2:0] allocSrcType, allocSrcRdy;
   logic allocRdt, allocRdValid;
   logic [W-1:0] wbValid, wbRegType;
   VRegIdx_t wbReg [W];
   logic [N-1:0] dispatchAck, opValid, rdt, rdValid;
   FuncCode_t opIn [N];
   FuncUnitType_t funcUnitType [N];
   VRegIdx_t ra [N], rb [N], rc [N], rd [N];
   logic [$clog2(N+1)-1:0] count;
   logic empty;
   modport master (
      output flush, allocValid, allocOp, allocFuType, allocRa, allocRb, allocRc, allocRd,
             allocSrcType, allocSrcRdy, allocRdt, allocRdValid, wbValid, wbRegType, wbReg, dispatchAck,
      input  allocReady, opValid, opIn, funcUnitType, ra, rb, rc, rd, rdt, rdValid, count, empty
   );
   modport slave (
      input  flush, allocValid, allocOp, allocFuType, allocRa, allocRb, allocRc, allocRd,
             allocSrcType, allocSrcRdy, allocRdt, allocRdValid, wbValid, wbRegType, wbReg, dispatchAck,
      output allocReady, opValid, opIn, funcUnitType, ra, rb, rc, rd, rdt, rdValid, count, empty
   );
endinterface

// File: rtl/rsv_station_wakeup.sv
// rsv_wakeup: compares three source tags against every writeback port, one hit bit per source.
module rsv_wakeup #(
   parameter int NUM_WB = rsv_station_pkg::NUM_WB
) (
   input  rsv_station_pkg::VRegIdx_t [2:0] src,
   input  logic [2:0] src_type,
   input  logic [NUM_WB-1:0] wb_valid,
   input  rsv_station_pkg::VRegIdx_t wb_reg [NUM_WB],
   input  logic [NUM_WB-1:0] wb_type,
   output logic [2:0] hit
);
   always_comb begin
      hit = '0;
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < NUM_WB; k++)
            hit[s] = hit[s] | (wb_valid[k] && wb_reg[k] == src[s] && wb_type[k] == src_type[s]);
   end
endmodule

// File: rtl/rsv_station.sv
// rsv_station: pool of op entries that wake on writeback tags and free on dispatch ack.
module rsv_station #(
   parameter int RSV_CAPACITY = rsv_station_pkg::RSV_CAPACITY,
   parameter int NUM_WB = rsv_station_pkg::NUM_WB
) (
   input logic clk,
   input logic rst,
   rsv_station_if.slave bus
);
   import rsv_station_pkg::*;
   localparam int IW = $clog2(RSV_CAPACITY);
   localparam int CW = $clog2(RSV_CAPACITY + 1);
   RsvEntry_t ent [RSV_CAPACITY];
   RsvEntry_t alloc_ent;
   logic [RSV_CAPACITY-1:0] occ, occ_n, ack_fire, alloc_hot;
   logic [2:0] hit [RSV_CAPACITY];
   logic [2:0] alloc_hit;
   logic [IW-1:0] alloc_idx;
   logic [CW-1:0] count, count_n;
   logic alloc_fire;
   always_comb begin
      alloc_idx = '0;
      for (int i = RSV_CAPACITY - 1; i >= 0; i--)
         if (!occ[i]) alloc_idx = IW'(i);
   end
   assign bus.allocReady = count != CW'(RSV_CAPACITY);
   assign bus.count = count;
   assign bus.empty = count == '0;
   assign alloc_fire = bus.allocValid && bus.allocReady;
   assign ack_fire = bus.dispatchAck & bus.opValid;
   assign alloc_hot = alloc_fire ? RSV_CAPACITY'(1) << alloc_idx : '0;
   assign occ_n = (occ & ~ack_fire) | alloc_hot;
   assign count_n = count + CW'(alloc_fire) - CW'($countones(ack_fire));
   // a tag broadcast in the alloc cycle is folded straight into the stored ready bits
   assign alloc_ent = '{
      op: bus.allocOp,
      fu_type: bus.allocFuType,
      src: {bus.allocRc, bus.allocRb, bus.allocRa},
      src_type: bus.allocSrcType,
      src_rdy: bus.allocSrcRdy | alloc_hit,
      rd: bus.allocRd,
      rdt: bus.allocRdt,
      rd_valid: bus.allocRdValid
   };
   rsv_wakeup #(.NUM_WB(NUM_WB)) u_alloc_wake (
      .src({bus.allocRc, bus.allocRb, bus.allocRa}),
      .src_type(bus.allocSrcType),
      .wb_valid(bus.wbValid),
      .wb_reg(bus.wbReg),
      .wb_type(bus.wbRegType),
      .hit(alloc_hit)
   );
   for (genvar g = 0; g < RSV_CAPACITY; g++) begin : g_ent
      rsv_wakeup #(.NUM_WB(NUM_WB)) u_wake (
         .src(ent[g].src),
         .src_type(ent[g].src_type),
         .wb_valid(bus.wbValid),
         .wb_reg(bus.wbReg),
         .wb_type(bus.wbRegType),
         .hit(hit[g])
      );
      assign bus.opValid[g] = occ[g] & (&ent[g].src_rdy);
      assign bus.opIn[g] = ent[g].op;
      assign bus.funcUnitType[g] = ent[g].fu_type;
      assign bus.ra[g] = ent[g].src[0];
      assign bus.rb[g] = ent[g].src[1];
      assign bus.rc[g] = ent[g].src[2];
      assign bus.rd[g] = ent[g].rd;
      assign bus.rdt[g] = ent[g].rdt;
      assign bus.rdValid[g] = ent[g].rd_valid;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         occ <= '0;
         count <= '0;
         for (int i = 0; i < RSV_CAPACITY; i++) ent[i] <= '0;
      end else if (bus.flush) begin
         occ <= '0;
         count <= '0;
      end else begin
         occ <= occ_n;
         count <= count_n;
         for (int i = 0; i < RSV_CAPACITY; i++)
            if (occ[i]) ent[i].src_rdy <= ent[i].src_rdy | hit[i];
         if (alloc_fire) ent[alloc_idx] <= alloc_ent;
      end
   end
   // an ack on a not-yet-ready entry is dropped; flag it so the offending dispatch unit is found
   always_ff @(posedge clk)
      if (!rst && !bus.flush)
         assert ((bus.dispatchAck & ~bus.opValid) == '0)
         else $warning("rsv_station: ack %b on non-ready entries (opValid %b) ignored", bus.dispatchAck, bus.opValid);
endmodule

// File: tb/tb_rsv_station.sv
// tb_rsv_station: directed plan steps plus a random run, checked against a slot-array model.
module tb_rsv_station;
   import rsv_station_pkg::*;
   localparam int N = RSV_CAPACITY;
   localparam int W = NUM_WB;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   bit m_occ [N];
   int m_op [N], m_fu [N], m_rd [N], m_rdt [N], m_rdv [N];
   int m_src [N][3], m_st [N][3], m_rdy [N][3];
   always #5 clk = ~clk;
   rsv_station_if #(.N(N), .W(W)) bus ();
   rsv_station #(.RSV_CAPACITY(N), .NUM_WB(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic bit wb_hit(int r, int t);
      for (int k = 0; k < W; k++)
         if (bus.wbValid[k] && int'(bus.wbReg[k]) == r && int'(bus.wbRegType[k]) == t) return 1'b1;
      return 1'b0;
   endfunction
   function automatic bit m_ready(int i);
      return m_occ[i] && m_rdy[i][0] != 0 && m_rdy[i][1] != 0 && m_rdy[i][2] != 0;
   endfunction
   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_occ[i]);
      return c;
   endfunction
   function automatic logic [63:0] obs_fields(int i);
      return {bus.opIn[i], 2'(bus.funcUnitType[i]), bus.ra[i], bus.rb[i], bus.rc[i], bus.rd[i], bus.rdt[i], bus.rdValid[i]};
   endfunction
   // model advances from the inputs presented this cycle, then the edge happens
   task automatic tick();
      logic [N-1:0] ack;
      int slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_occ[i]) slot = i;
      for (int i = 0; i < N; i++) ack[i] = bus.dispatchAck[i] && m_ready(i);
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_occ[i] = 0; m_op[i] = 0; m_fu[i] = 0; m_rd[i] = 0; m_rdt[i] = 0; m_rdv[i] = 0;
            for (int s = 0; s < 3; s++) begin m_src[i][s] = 0; m_st[i][s] = 0; m_rdy[i][s] = 0; end
         end
      end else if (bus.flush) begin
         for (int i = 0; i < N; i++) m_occ[i] = 0;
      end else begin
         for (int i = 0; i < N; i++)
            if (m_occ[i])
               for (int s = 0; s < 3; s++) if (wb_hit(m_src[i][s], m_st[i][s])) m_rdy[i][s] = 1;
         if (bus.allocValid && slot >= 0) begin
            m_occ[slot] = 1;
            m_op[slot] = int'(bus.allocOp);
            m_fu[slot] = int'(bus.allocFuType);
            m_src[slot][0] = int'(bus.allocRa);
            m_src[slot][1] = int'(bus.allocRb);
            m_src[slot][2] = int'(bus.allocRc);
            m_rd[slot] = int'(bus.allocRd);
            m_rdt[slot] = int'(bus.allocRdt);
            m_rdv[slot] = int'(bus.allocRdValid);
            for (int s = 0; s < 3; s++) begin
               m_st[slot][s] = int'(bus.allocSrcType[s]);
               m_rdy[slot][s] = int'(bus.allocSrcRdy[s] | wb_hit(m_src[slot][s], m_st[slot][s]));
            end
         end
         for (int i = 0; i < N; i++) if (ack[i]) m_occ[i] = 0;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic check_all();
      logic [N-1:0] ev;
      for (int i = 0; i < N; i++) ev[i] = m_ready(i);
      chk("opValid", bus.opValid, ev);
      chk("count", bus.count, m_count());
      chk("empty", bus.empty, m_count() == 0);
      chk("allocReady", bus.allocReady, m_count() != N);
      for (int i = 0; i < N; i++)
         if (m_occ[i])
            chk($sformatf("entry%0d", i), obs_fields(i),
                {6'(m_op[i]), 2'(m_fu[i]), 6'(m_src[i][0]), 6'(m_src[i][1]), 6'(m_src[i][2]),
                 6'(m_rd[i]), 1'(m_rdt[i]), 1'(m_rdv[i])});
   endtask
   task automatic check_reset();
      chk("rst_opValid", bus.opValid, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_allocReady", bus.allocReady, 1);
      for (int i = 0; i < N; i++) chk($sformatf("rst_fields%0d", i), obs_fields(i), 0);
   endtask
   task automatic idle();
      bus.flush = 0; bus.allocValid = 0; bus.allocOp = '0; bus.allocFuType = FU_ALU;
      bus.allocRa = '0; bus.allocRb = '0; bus.allocRc = '0; bus.allocRd = '0;
      bus.allocSrcType = '0; bus.allocSrcRdy = '0; bus.allocRdt = 0; bus.allocRdValid = 0;
      bus.wbValid = '0; bus.wbRegType = '0; bus.dispatchAck = '0;
      for (int k = 0; k < W; k++) bus.wbReg[k] = '0;
   endtask
   task automatic set_alloc(int op, int a, int b, int c, int st, int sr);
      bus.allocValid = 1;
      bus.allocOp = 6'(op);
      bus.allocFuType = FuncUnitType_t'(op % 4);
      bus.allocRa = 6'(a);
      bus.allocRb = 6'(b);
      bus.allocRc = 6'(c);
      bus.allocSrcType = 3'(st);
      bus.allocSrcRdy = 3'(sr);
      bus.allocRd = 6'(op + a);
      bus.allocRdt = 1'(op & 1);
      bus.allocRdValid = 1'((op >> 1) & 1);
   endtask
   task automatic fill(int n, int base);
      for (int j = 0; j < n; j++) begin
         idle();
         set_alloc(base + j, j, j + 8, j + 16, j & 7, 7);
         tick();
         check_all();
      end
      idle();
   endtask
   initial begin
      idle();
      rst = 1;
      tick();
      rst = 0;
      check_reset();
      check_all();
      for (int j = 0; j < N; j++) begin
         set_alloc(j + 1, j, j + 8, j + 16, 3'b010, 3'b111);
         tick();
         check_all();
         chk("fill_valid", bus.opValid, (64'd1 << (j + 1)) - 1);
      end
      chk("full_ready", bus.allocReady, 0);
      set_alloc(40, 1, 1, 1, 0, 7);
      tick();
      check_all();
      chk("ninth_dropped", bus.count, N);
      chk("full_valid", bus.opValid, 8'hFF);
      idle();
      bus.flush = 1;
      tick();
      check_all();
      chk("flush_count", bus.count, 0);
      idle();
      set_alloc(9, 5, 1, 2, 3'b001, 3'b110);
      tick();
      idle();
      check_all();
      chk("ra_wait", bus.opValid[0], 0);
      bus.wbValid = 2'b10; bus.wbReg[1] = 6'd5; bus.wbRegType = 2'b00;
      tick();
      check_all();
      chk("wrong_type", bus.opValid[0], 0);
      bus.wbRegType = 2'b10;
      tick();
      check_all();
      chk("wake", bus.opValid[0], 1);
      idle();
      set_alloc(10, 0, 7, 0, 3'b000, 3'b101);
      bus.wbValid = 2'b01; bus.wbReg[0] = 6'd7; bus.wbRegType = 2'b00;
      tick();
      idle();
      check_all();
      chk("bypass", bus.opValid[1], 1);
      bus.flush = 1;
      tick();
      fill(N, 20);
      bus.dispatchAck = 8'b0100_0100;
      tick();
      idle();
      check_all();
      chk("ack2_count", bus.count, 6);
      chk("ack2_ready", bus.allocReady, 1);
      set_alloc(50, 33, 0, 0, 0, 7);
      tick();
      check_all();
      chk("land2", bus.ra[2], 33);
      set_alloc(51, 34, 0, 0, 0, 7);
      tick();
      check_all();
      chk("land6", bus.ra[6], 34);
      set_alloc(52, 35, 0, 0, 0, 7);
      bus.dispatchAck = 8'b0000_0001;
      tick();
      check_all();
      chk("full_ack_drop", bus.count, 7);
      idle();
      bus.flush = 1;
      tick();
      idle();
      set_alloc(12, 3, 3, 3, 0, 3'b011);
      tick();
      idle();
      bus.dispatchAck = 8'b0000_0001;
      tick();
      check_all();
      chk("bad_ack_count", bus.count, 1);
      chk("bad_ack_ready", bus.allocReady, 1);
      set_alloc(13, 4, 4, 4, 0, 7);
      bus.flush = 1;
      tick();
      idle();
      check_all();
      chk("flush_count2", bus.count, 0);
      chk("flush_valid", bus.opValid, 0);
      fill(4, 30);
      chk("mid_count", bus.count, 4);
      set_alloc(60, 1, 2, 3, 0, 7);
      rst = 1;
      tick();
      rst = 0;
      idle();
      check_reset();
      check_all();
      for (int n = 0; n < 400; n++) begin
         logic [N-1:0] rm;
         idle();
         set_alloc($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         bus.allocValid = $urandom_range(0, 9) < 7;
         bus.wbValid = W'($urandom);
         bus.wbRegType = W'($urandom);
         for (int k = 0; k < W; k++) bus.wbReg[k] = 6'($urandom_range(0, 7));
         for (int i = 0; i < N; i++) rm[i] = m_ready(i);
         bus.dispatchAck = N'($urandom) & rm;
         bus.flush = $urandom_range(0, 39) == 0;
         rst = $urandom_range(0, 99) == 0;
         tick();
         check_all();
      end
      rst = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
